// File: rtl/mux_seq_pkg.sv
// mux_seq_pkg: shared types and constants for the sequential N:1 mux.
//   state_t : block operating state (IDLE / MANUAL / SCAN)
//   DWELL_W : width of the dwell counter
package mux_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam int unsigned DWELL_W = 8;

endpackage

// File: rtl/mux_seq_sel_ctrl.sv
// mux_seq_sel_ctrl: state machine, dwell counter and select generation.
// Optional feature: MUX_SEQ_MASK_EN adds ch_mask and masked scanning.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   en, mode         enable / 0=manual 1=scan
//   sel_in, sel_load select value and load strobe
//   ch_mask          per-channel scan enable (MUX_SEQ_MASK_EN only)
//   sel              select register (channel to sample at next update)
//   upd              this edge updates the output registers
//   wrap_pend        sel last moved by wrapping and is not yet on sel_out
module mux_seq_sel_ctrl
    import mux_seq_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned DWELL = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 mode,
    input  logic [$clog2(N)-1:0] sel_in,
    input  logic                 sel_load,
`ifdef MUX_SEQ_MASK_EN
    input  logic [N-1:0]         ch_mask,
`endif
    output logic [$clog2(N)-1:0] sel,
    output logic                 upd,
    output logic                 wrap_pend
);

    localparam int unsigned SEL_W = $clog2(N);

    state_t               st_q, st_d;
    logic [SEL_W-1:0]     sel_d, nxt;
    logic [DWELL_W-1:0]   cnt_q, cnt_d, cur_cnt;
    logic                 wp_d, nxt_wrap, any_ch;

    // Next channel to scan and whether reaching it counts as a wrap.
`ifdef MUX_SEQ_MASK_EN
    logic [SEL_W-1:0] idx;
    logic             found;
    always_comb begin
        nxt    = sel;
        idx    = '0;
        found  = 1'b0;
        any_ch = |ch_mask;
        // i = N lands back on sel itself, covering a single-channel mask.
        for (int unsigned i = 1; i <= N; i++) begin
            idx = sel + SEL_W'(i);
            if (!found && ch_mask[idx]) begin
                found = 1'b1;
                nxt   = idx;
            end
        end
        nxt_wrap = (nxt <= sel);
    end
`else
    always_comb begin
        nxt      = sel + SEL_W'(1);
        nxt_wrap = (sel == SEL_W'(N - 1));
        any_ch   = 1'b1;
    end
`endif

    always_comb begin
        st_d = IDLE;
        if (en) st_d = mode ? SCAN : MANUAL;

        sel_d   = sel;
        cnt_d   = cnt_q;
        wp_d    = wrap_pend;
        upd     = 1'b0;
        // Coming straight from MANUAL, the dwell starts over from zero.
        cur_cnt = (st_q == MANUAL) ? '0 : cnt_q;

        case (st_d)
            MANUAL: begin
                upd  = 1'b1;
                wp_d = 1'b0;
                if (sel_load) sel_d = sel_in;
            end
            SCAN: begin
                if (any_ch) begin
                    upd  = 1'b1;
                    wp_d = 1'b0;
                    if (sel_load) begin
                        sel_d = sel_in;
                        cnt_d = '0;
                    end else if (cur_cnt == DWELL_W'(DWELL - 1)) begin
                        sel_d = nxt;
                        cnt_d = '0;
                        wp_d  = nxt_wrap;
                    end else begin
                        cnt_d = cur_cnt + DWELL_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q      <= IDLE;
            sel       <= '0;
            cnt_q     <= '0;
            wrap_pend <= 1'b0;
        end else begin
            st_q      <= st_d;
            sel       <= sel_d;
            cnt_q     <= cnt_d;
            wrap_pend <= wp_d;
        end
    end

endmodule

// File: rtl/mux_seq_nx1.sv
// mux_seq_nx1: sequential N:1 mux with manual select and auto scan.
// Optional feature: MUX_SEQ_MASK_EN adds ch_mask (scan only enabled channels).
// Ports:
//   clk, rst_n   clock, async active-low reset
//   en           update enable (0 freezes everything, valid drops)
//   mode         0 = manual select, 1 = auto scan
//   sel_in       channel index to load; sel_load loads it
//   din          packed channels, channel k at [k*WIDTH +: WIDTH]
//   ch_mask      channel scan enables (MUX_SEQ_MASK_EN only)
//   dout         registered selected channel
//   sel_out      channel index carried by dout
//   valid        dout/sel_out hold a fresh sample
//   wrap         pulse when sel_out first shows the post-wrap channel
module mux_seq_nx1
    import mux_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 8,
    parameter int unsigned DWELL = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 mode,
    input  logic [$clog2(N)-1:0] sel_in,
    input  logic                 sel_load,
    input  logic [N*WIDTH-1:0]   din,
`ifdef MUX_SEQ_MASK_EN
    input  logic [N-1:0]         ch_mask,
`endif
    output logic [WIDTH-1:0]     dout,
    output logic [$clog2(N)-1:0] sel_out,
    output logic                 valid,
    output logic                 wrap
);

    localparam int unsigned SEL_W = $clog2(N);

    logic [SEL_W-1:0] sel;
    logic             upd, wrap_pend;
    logic [WIDTH-1:0] mux_d;

    mux_seq_sel_ctrl #(
        .N     (N),
        .DWELL (DWELL)
    ) u_sel_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .sel_in    (sel_in),
        .sel_load  (sel_load),
`ifdef MUX_SEQ_MASK_EN
        .ch_mask   (ch_mask),
`endif
        .sel       (sel),
        .upd       (upd),
        .wrap_pend (wrap_pend)
    );

    always_comb begin
        mux_d = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (sel == SEL_W'(k)) mux_d = din[k*WIDTH +: WIDTH];
        end
    end

    // The wrap is flagged when sel wraps and released one update later,
    // so it lines up with sel_out showing the new channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout    <= '0;
            sel_out <= '0;
            valid   <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            valid <= upd;
            wrap  <= upd & wrap_pend;
            if (upd) begin
                dout    <= mux_d;
                sel_out <= sel;
            end
        end
    end

endmodule

// File: tb/tb_mux_seq_nx1.sv
module tb_mux_seq_nx1;

    localparam int unsigned W     = 8;
    localparam int unsigned N     = 8;
    localparam int unsigned DWELL = 2;

    logic           clk = 1'b0;
    logic           rst_n, en, mode, sel_load;
    logic [2:0]     sel_in;
    logic [N*W-1:0] din;
`ifdef MUX_SEQ_MASK_EN
    logic [N-1:0]   ch_mask;
`endif
    logic [W-1:0]   dout;
    logic [2:0]     sel_out;
    logic           valid, wrap;

    always #5 clk = ~clk;

    mux_seq_nx1 #(.WIDTH(W), .N(N), .DWELL(DWELL)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .sel_in   (sel_in),
        .sel_load (sel_load),
        .din      (din),
`ifdef MUX_SEQ_MASK_EN
        .ch_mask  (ch_mask),
`endif
        .dout     (dout),
        .sel_out  (sel_out),
        .valid    (valid),
        .wrap     (wrap)
    );

    typedef struct {
        logic       en, mode, load;
        logic [2:0] sel_in;
        logic [2:0] e_sel;
        logic       e_valid, e_wrap;
        string      name;
    } vec_t;

    typedef struct {
        logic [W-1:0] dout;
        logic [2:0]   sel;
        logic         valid, wrap;
        string        name;
    } exp_t;

    exp_t         sbq[$];
    vec_t         tbl[29];
    logic [W-1:0] mdout;
    int           n_vec = 0;
    int           n_err = 0;

    function automatic vec_t mk(logic e, logic m, logic l, logic [2:0] si,
                                logic [2:0] es, logic ev, logic ew, string nm);
        vec_t v;
        v.en = e; v.mode = m; v.load = l; v.sel_in = si;
        v.e_sel = es; v.e_valid = ev; v.e_wrap = ew; v.name = nm;
        return v;
    endfunction

    // Expected dout: channel k carries 8'h10+k; held whenever valid is 0.
    task automatic push_exp(logic [2:0] s, logic v, logic w, string nm);
        exp_t e;
        if (v) mdout = 8'h10 + {5'b0, s};
        e.dout = mdout; e.sel = s; e.valid = v; e.wrap = w; e.name = nm;
        sbq.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sbq.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: no expected record for sampled output");
            return;
        end
        e = sbq.pop_front();
        n_vec++;
        if (dout !== e.dout || sel_out !== e.sel || valid !== e.valid || wrap !== e.wrap) begin
            n_err++;
            $display("FAIL %s: got dout=%h sel_out=%0d valid=%b wrap=%b, want dout=%h sel_out=%0d valid=%b wrap=%b",
                     e.name, dout, sel_out, valid, wrap, e.dout, e.sel, e.valid, e.wrap);
        end
    endtask

    task automatic drive_check(vec_t v);
        en = v.en; mode = v.mode; sel_load = v.load; sel_in = v.sel_in;
        push_exp(v.e_sel, v.e_valid, v.e_wrap, v.name);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic apply(vec_t v);
        @(negedge clk);
        drive_check(v);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel_load = 1'b0; sel_in = '0;
        mdout = '0;
`ifdef MUX_SEQ_MASK_EN
        ch_mask = '1;
`endif
        for (int k = 0; k < N; k++) din[k*W +: W] = 8'h10 + k[7:0];

        //            en mode ld si  sel v  w
        tbl[0]  = mk(0, 0, 0, 0,  0, 0, 0, "idle_after_reset");
        tbl[1]  = mk(1, 0, 0, 0,  0, 1, 0, "first_edge_ch0");
        tbl[2]  = mk(1, 0, 1, 3,  0, 1, 0, "manual_load3");
        tbl[3]  = mk(1, 0, 0, 0,  3, 1, 0, "manual_shows3");
        tbl[4]  = mk(1, 0, 0, 0,  3, 1, 0, "manual_hold3");
        tbl[5]  = mk(0, 0, 0, 0,  3, 0, 0, "idle_hold");
        tbl[6]  = mk(1, 1, 0, 0,  3, 1, 0, "scan_3a");
        tbl[7]  = mk(1, 1, 0, 0,  3, 1, 0, "scan_3b");
        tbl[8]  = mk(1, 1, 0, 0,  4, 1, 0, "scan_4a");
        tbl[9]  = mk(1, 1, 0, 0,  4, 1, 0, "scan_4b");
        tbl[10] = mk(1, 1, 0, 0,  5, 1, 0, "scan_5a");
        tbl[11] = mk(1, 1, 1, 6,  5, 1, 0, "prio_load6");
        tbl[12] = mk(1, 1, 0, 0,  6, 1, 0, "prio_6a");
        tbl[13] = mk(1, 1, 0, 0,  6, 1, 0, "prio_6b_full_dwell");
        tbl[14] = mk(1, 1, 0, 0,  7, 1, 0, "scan_7a");
        for (int i = 15; i < 20; i++)
            tbl[i] = mk(0, 1, 0, 0, 7, 0, 0, "en_low_frozen");
        tbl[20] = mk(1, 1, 0, 0,  7, 1, 0, "resume_remaining");
        tbl[21] = mk(1, 1, 0, 0,  0, 1, 1, "wrap_7_to_0");
        tbl[22] = mk(1, 0, 0, 0,  0, 1, 0, "scan_to_manual");
        tbl[23] = mk(1, 0, 0, 0,  0, 1, 0, "manual_frozen_sel");
        tbl[24] = mk(1, 1, 0, 0,  0, 1, 0, "manual_to_scan_c0");
        tbl[25] = mk(1, 1, 0, 0,  0, 1, 0, "manual_to_scan_c1");
        tbl[26] = mk(1, 1, 0, 0,  1, 1, 0, "scan_1a");
        tbl[27] = mk(1, 0, 1, 5,  1, 1, 0, "manual_load5");
        tbl[28] = mk(1, 1, 0, 0,  5, 1, 0, "scan_at_5");

        @(posedge clk);
        #1;
        push_exp(0, 0, 0, "reset_state");
        check_out();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 29; i++) apply(tbl[i]);

        // Asynchronous reset in mid-cycle while scanning with sel=5.
        #2;
        rst_n = 1'b0;
        #1;
        mdout = '0;
        push_exp(0, 0, 0, "async_reset_midscan");
        check_out();

        // Release with en=1: first edge samples channel 0, then full scan.
        @(negedge clk);
        rst_n = 1'b1;
        drive_check(mk(1, 1, 0, 0, 0, 1, 0, "post_reset_ch0"));
        for (int t = 2; t <= 18; t++) begin
            logic [2:0] es;
            es = 3'(((t - 1) / 2) % 8);
            apply(mk(1, 1, 0, 0, es, 1, (t == 17), "scan_sweep"));
        end

`ifdef MUX_SEQ_MASK_EN
        begin
            logic [2:0] mseq [9];
            mseq = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd4, 3'd4, 3'd7, 3'd7, 3'd1};
            @(negedge clk);
            rst_n = 1'b0; en = 1'b0;
            ch_mask = 8'b1001_0010;
            #1;
            mdout = '0;
            rst_n = 1'b1;
            for (int i = 0; i < 9; i++)
                apply(mk(1, 1, 0, 0, mseq[i], 1, (i == 8), "mask_scan"));
            ch_mask = '0;
            apply(mk(1, 1, 0, 0, 3'd1, 0, 0, "mask_empty_hold"));
            apply(mk(1, 1, 0, 0, 3'd1, 0, 0, "mask_empty_hold2"));
        end
`endif

        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover: %0d records unchecked, want 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
